// File: rtl/manchester_decoder2.sv
// Manchester decoder (01 -> 1, 10 -> 0) over 0-3 half-bits per clock.
// Outputs are registered with one cycle of latency. There is no backpressure: every clock accepts whatever half-bits are offered.
module manchester_decoder2 #(
    parameter logic [7:0] SYNC_WORD  = 8'hD5,
    parameter int         LOCK_COUNT = 8
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic [2:0] bits,
    input  logic [2:0] num_bits,
    output logic [7:0] out_byte,
    output logic       out_valid,
    output logic       locked,
    output logic       in_frame,
    output logic       code_err
);

    localparam int            CW       = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_COUNT);

    logic          res_vld_q, res_vld_d;
    logic          res_q, res_d;
    logic [CW-1:0] pair_cnt_q, pair_cnt_d;
    logic          locked_q, locked_d;
    logic          in_frame_q, in_frame_d;
    logic [7:0]    sync_q, sync_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    out_byte_q, out_byte_d;
    logic          out_valid_q, out_valid_d;
    logic          code_err_q, code_err_d;

    always_comb begin
        logic [1:0] new_cnt;
        logic [2:0] new_hb;
        logic [3:0] cur;
        logic [2:0] rem;
        logic       dbit;

        res_vld_d   = res_vld_q;
        res_d       = res_q;
        pair_cnt_d  = pair_cnt_q;
        locked_d    = locked_q;
        in_frame_d  = in_frame_q;
        sync_d      = sync_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        out_byte_d  = out_byte_q;
        out_valid_d = 1'b0;
        code_err_d  = 1'b0;
        dbit        = 1'b0;

        new_cnt = (num_bits <= 3'd3) ? num_bits[1:0] : 2'd0;
        case (new_cnt)
            2'd1:    new_hb = {bits[0], 2'b00};
            2'd2:    new_hb = {bits[1:0], 1'b0};
            2'd3:    new_hb = bits;
            default: new_hb = 3'b000;
        endcase

        // Working stream is left-justified in cur: cur[3] is always the oldest unconsumed half-bit.
        if (res_vld_q) begin
            cur = {res_q, new_hb};
            rem = {1'b0, new_cnt} + 3'd1;
        end else begin
            cur = {new_hb, 1'b0};
            rem = {1'b0, new_cnt};
        end

        for (int step = 0; step < 3; step++) begin
            if (rem >= 3'd2) begin
                if (cur[3] == cur[2]) begin
                    code_err_d = 1'b1;
                    pair_cnt_d = '0;
                    locked_d   = 1'b0;
                    in_frame_d = 1'b0;
                    sync_d     = 8'h00;
                    bit_cnt_d  = 3'd0;
                    shift_d    = 8'h00;
                    cur        = cur << 1;
                    rem        = rem - 3'd1;
                end else begin
                    dbit = cur[2];
                    cur  = cur << 2;
                    rem  = rem - 3'd2;
                    if (pair_cnt_d != LOCK_MAX) begin
                        pair_cnt_d = pair_cnt_d + CW'(1);
                    end
                    locked_d = (pair_cnt_d == LOCK_MAX);
                    if (in_frame_d) begin
                        shift_d = {shift_d[6:0], dbit};
                        if (bit_cnt_d == 3'd7) begin
                            out_byte_d  = shift_d;
                            out_valid_d = 1'b1;
                            bit_cnt_d   = 3'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_d + 3'd1;
                        end
                    end else begin
                        sync_d = {sync_d[6:0], dbit};
                        if (locked_d && sync_d == SYNC_WORD) begin
                            in_frame_d = 1'b1;
                            bit_cnt_d  = 3'd0;
                        end
                    end
                end
            end
        end

        res_vld_d = (rem == 3'd1);
        res_d     = (rem == 3'd1) ? cur[3] : 1'b0;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            res_vld_q   <= 1'b0;
            res_q       <= 1'b0;
            pair_cnt_q  <= '0;
            locked_q    <= 1'b0;
            in_frame_q  <= 1'b0;
            sync_q      <= 8'h00;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            out_byte_q  <= 8'h00;
            out_valid_q <= 1'b0;
            code_err_q  <= 1'b0;
        end else begin
            res_vld_q   <= res_vld_d;
            res_q       <= res_d;
            pair_cnt_q  <= pair_cnt_d;
            locked_q    <= locked_d;
            in_frame_q  <= in_frame_d;
            sync_q      <= sync_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            code_err_q  <= code_err_d;
        end
    end

    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
    assign locked    = locked_q;
    assign in_frame  = in_frame_q;
    assign code_err  = code_err_q;

endmodule

// File: tb/tb_manchester_decoder2.sv
// Scoreboard bench for manchester_decoder2: expected bytes are queued while the half-bit stream is built,
// and each test compares them against the bytes that the monitor collected from the out_valid pulses.
module tb_manchester_decoder2;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic [2:0] bits = 3'd0;
    logic [2:0] num_bits = 3'd0;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       locked;
    logic       in_frame;
    logic       code_err;

    always #5 aclk = ~aclk;

    manchester_decoder2 dut (
        .aclk     (aclk),
        .areset   (areset),
        .bits     (bits),
        .num_bits (num_bits),
        .out_byte (out_byte),
        .out_valid(out_valid),
        .locked   (locked),
        .in_frame (in_frame),
        .code_err (code_err)
    );

    logic       hb_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int err_cnt = 0;
    int lock_hb = -1;
    int frame_hb = -1;
    int hb_sampled = 0;
    int n_pass = 0;
    int n_checks = 0;

    always @(posedge aclk) begin
        if (areset) hb_sampled = 0;
        else if (num_bits <= 3'd3) hb_sampled += int'(num_bits);
    end

    always @(negedge aclk) begin
        if (out_valid) got_q.push_back(out_byte);
        if (code_err) err_cnt++;
        if (locked && lock_hb < 0) lock_hb = hb_sampled;
        if (in_frame && frame_hb < 0) frame_hb = hb_sampled;
    end

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        hb_q.delete();
        err_cnt  = 0;
        lock_hb  = -1;
        frame_hb = -1;
    endtask

    task automatic do_reset(input int cyc);
        @(negedge aclk);
        areset = 1'b1;
        bits = 3'd0;
        num_bits = 3'd0;
        repeat (cyc) @(negedge aclk);
        clear_mon();
        areset = 1'b0;
    endtask

    task automatic add_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            hb_q.push_back(~v[i]);
            hb_q.push_back(v[i]);
        end
    endtask

    task automatic add_frame();
        add_byte(8'hAA); add_byte(8'hAA); add_byte(8'hD5);
        add_byte(8'hAA); add_byte(8'hBB); add_byte(8'hCC); add_byte(8'hDD);
        exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
        exp_q.push_back(8'hCC); exp_q.push_back(8'hDD);
    endtask

    // mode 0: one half-bit then pairs; 1: triples; 2: random sizes with junk cycles; else pairs
    task automatic send(input int mode);
        int k;
        logic [2:0] b;
        bit first = 1'b1;
        while (hb_q.size() > 0) begin
            if (mode == 2 && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(negedge aclk);
                    bits = 3'($urandom);
                    case ($urandom_range(0, 2))
                        0:       num_bits = 3'd0;
                        1:       num_bits = 3'd5;
                        default: num_bits = 3'd7;
                    endcase
                end
            end
            case (mode)
                0:       k = first ? 1 : 2;
                1:       k = 3;
                2:       k = int'($urandom_range(1, 3));
                default: k = 2;
            endcase
            first = 1'b0;
            if (k > hb_q.size()) k = hb_q.size();
            b = 3'd0;
            repeat (k) b = {b[1:0], hb_q.pop_front()};
            @(negedge aclk);
            bits = b;
            num_bits = 3'(k);
        end
        @(negedge aclk);
        bits = 3'd0;
        num_bits = 3'd0;
        repeat (3) @(negedge aclk);
    endtask

    task automatic test_reset();
        do_reset(5);
        n_checks++; if (out_byte !== 8'h00) $display("FAIL reset_out_byte: got %h want 00", out_byte); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else n_pass++;
        n_checks++; if (in_frame !== 1'b0) $display("FAIL reset_in_frame: got %b want 0", in_frame); else n_pass++;
        n_checks++; if (code_err !== 1'b0) $display("FAIL reset_code_err: got %b want 0", code_err); else n_pass++;
    endtask

    task automatic test_two_per_cycle();
        logic [7:0] e, g;
        add_frame();
        send(0);
        n_checks++; if (lock_hb !== 17) $display("FAIL p2_lock_point: got %0d want 17", lock_hb); else n_pass++;
        n_checks++; if (frame_hb !== 49) $display("FAIL p2_frame_point: got %0d want 49", frame_hb); else n_pass++;
        n_checks++; if (err_cnt !== 0) $display("FAIL p2_code_err: got %0d want 0", err_cnt); else n_pass++;
        n_checks++; if (got_q.size() !== 4) $display("FAIL p2_count: got %0d want 4", got_q.size()); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) $display("FAIL p2_byte: got none want %h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL p2_byte: got %h want %h", g, e); else n_pass++;
            end
        end
        n_checks++; if (in_frame !== 1'b1) $display("FAIL p2_in_frame_end: got %b want 1", in_frame); else n_pass++;
    endtask

    task automatic test_three_per_cycle();
        logic [7:0] e, g;
        do_reset(2);
        add_frame();
        send(1);
        n_checks++; if (lock_hb !== 18) $display("FAIL p3_lock_point: got %0d want 18", lock_hb); else n_pass++;
        n_checks++; if (err_cnt !== 0) $display("FAIL p3_code_err: got %0d want 0", err_cnt); else n_pass++;
        n_checks++; if (got_q.size() !== 4) $display("FAIL p3_count: got %0d want 4", got_q.size()); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) $display("FAIL p3_byte: got none want %h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL p3_byte: got %h want %h", g, e); else n_pass++;
            end
        end
    endtask

    task automatic test_stray_halfbit();
        logic [7:0] e, g;
        do_reset(2);
        hb_q.push_back(1'b0);
        add_frame();
        send(0);
        n_checks++; if (err_cnt !== 1) $display("FAIL stray_code_err: got %0d want 1", err_cnt); else n_pass++;
        n_checks++; if (got_q.size() !== 4) $display("FAIL stray_count: got %0d want 4", got_q.size()); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) $display("FAIL stray_byte: got none want %h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL stray_byte: got %h want %h", g, e); else n_pass++;
            end
        end
    endtask

    task automatic test_idle_junk();
        logic [7:0] e, g;
        do_reset(2);
        add_frame();
        send(2);
        n_checks++; if (err_cnt !== 0) $display("FAIL junk_code_err: got %0d want 0", err_cnt); else n_pass++;
        n_checks++; if (got_q.size() !== 4) $display("FAIL junk_count: got %0d want 4", got_q.size()); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) $display("FAIL junk_byte: got none want %h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL junk_byte: got %h want %h", g, e); else n_pass++;
            end
        end
    endtask

    task automatic test_violation();
        logic [7:0] e, g;
        do_reset(2);
        add_byte(8'hAA); add_byte(8'hAA); add_byte(8'hD5);
        // first three bits of 0xAA (1,0,1), then the illegal pair 11
        hb_q.push_back(1'b0); hb_q.push_back(1'b1);
        hb_q.push_back(1'b1); hb_q.push_back(1'b0);
        hb_q.push_back(1'b0); hb_q.push_back(1'b1);
        hb_q.push_back(1'b1); hb_q.push_back(1'b1);
        send(4);
        n_checks++; if (err_cnt !== 1) $display("FAIL viol_code_err: got %0d want 1", err_cnt); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL viol_locked: got %b want 0", locked); else n_pass++;
        n_checks++; if (in_frame !== 1'b0) $display("FAIL viol_in_frame: got %b want 0", in_frame); else n_pass++;
        n_checks++; if (got_q.size() !== 0) $display("FAIL viol_no_output: got %0d want 0", got_q.size()); else n_pass++;
        // the pending residue 1 forces one realignment slip in the fresh preamble
        add_byte(8'hAA); add_byte(8'hAA); add_byte(8'hD5); add_byte(8'hBB);
        exp_q.push_back(8'hBB);
        send(4);
        n_checks++; if (err_cnt !== 2) $display("FAIL viol_realign_err: got %0d want 2", err_cnt); else n_pass++;
        n_checks++; if (got_q.size() !== 1) $display("FAIL viol_count: got %0d want 1", got_q.size()); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) $display("FAIL viol_byte: got none want %h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL viol_byte: got %h want %h", g, e); else n_pass++;
            end
        end
        n_checks++; if (in_frame !== 1'b1) $display("FAIL viol_reframe: got %b want 1", in_frame); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] e, g;
        do_reset(2);
        add_byte(8'hAA); add_byte(8'hAA); add_byte(8'hD5); add_byte(8'hAA);
        hb_q.push_back(1'b0);
        send(4);
        n_checks++; if (in_frame !== 1'b1) $display("FAIL mid_in_frame_before: got %b want 1", in_frame); else n_pass++;
        n_checks++; if (got_q.size() !== 1) $display("FAIL mid_count_before: got %0d want 1", got_q.size()); else n_pass++;
        @(negedge aclk);
        areset = 1'b1;
        bits = 3'b111;
        num_bits = 3'd3;
        @(negedge aclk);
        n_checks++; if (out_byte !== 8'h00) $display("FAIL mid_out_byte: got %h want 00", out_byte); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (locked !== 1'b0) $display("FAIL mid_locked: got %b want 0", locked); else n_pass++;
        n_checks++; if (in_frame !== 1'b0) $display("FAIL mid_in_frame: got %b want 0", in_frame); else n_pass++;
        n_checks++; if (code_err !== 1'b0) $display("FAIL mid_code_err: got %b want 0", code_err); else n_pass++;
        clear_mon();
        areset = 1'b0;
        bits = 3'd0;
        num_bits = 3'd0;
        add_frame();
        send(0);
        n_checks++; if (err_cnt !== 0) $display("FAIL mid_after_err: got %0d want 0", err_cnt); else n_pass++;
        n_checks++; if (lock_hb !== 17) $display("FAIL mid_after_lock: got %0d want 17", lock_hb); else n_pass++;
        n_checks++; if (got_q.size() !== 4) $display("FAIL mid_after_count: got %0d want 4", got_q.size()); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) $display("FAIL mid_byte: got none want %h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL mid_byte: got %h want %h", g, e); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_per_cycle();
        test_three_per_cycle();
        test_stray_halfbit();
        test_idle_junk();
        test_violation();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/manchester_decoder2.md
Name: manchester_decoder2

Overview:
- Streaming Manchester decoder (IEEE 802.3 convention: bit 1 = half-bits 01, bit 0 = half-bits 10).
- Sits after a deserializer/oversampler that delivers 0-3 recovered half-bits per clock.
- Recovers pair alignment, declares lock, hunts for a sync byte, then emits MSB-first bytes.

Parameters:
SYNC_WORD, 8'hD5, byte that marks start of frame (matched on the decoded bit stream).
LOCK_COUNT, 8, consecutive valid pairs required before locked asserts.

Ports:
aclk  input  1  clock; all logic on rising edge.
areset  input  1  synchronous, active-high reset; priority over all inputs.
bits  input  3  new half-bits, right-justified; bits[num_bits-1] is oldest, bits[0] newest.
num_bits  input  3  count of valid half-bits in bits (0-3); values 4-7 treated as 0.
out_byte  output  8  last completed frame byte, MSB = first decoded bit.
out_valid  output  1  one-cycle pulse when out_byte updates.
locked  output  1  pair alignment established.
in_frame  output  1  sync found, byte assembly active.
code_err  output  1  one-cycle pulse on any Manchester violation.

Behaviour:
- Reset (areset=1 at edge): residue empty, pair counter 0, sync shift register 0, bit counter 0, out_byte=0, out_valid=0, locked=0, in_frame=0, code_err=0. Input that cycle discarded.
- Each cycle, working stream = stored residue half-bit (0 or 1) followed by the new half-bits, oldest first; max 4 half-bits.
- Pairing, left to right:
  - 01 decodes to 1; 10 decodes to 0.
  - 00 or 11 is a violation: drop the first half-bit only (slip one half-bit) and re-pair starting at the second.
  - Unpaired last half-bit becomes next cycle's residue.
  - At most 2 decoded bits per cycle.
- Bits are processed sequentially in stream order within a cycle. Effects of one bit (sync match, byte completion) apply before the next bit.
- Violation effects, in the cycle it occurs:
  - pair counter=0, locked=0, in_frame=0, partial byte and bit counter cleared, sync register cleared.
  - code_err=1 next cycle.
  - Subsequent valid pairs in the same cycle count from zero.
- Each valid pair increments the pair counter, saturating at LOCK_COUNT. locked=1 once counter==LOCK_COUNT.
- Every decoded bit shifts into the sync register (MSB-first) while not in_frame.
- When locked and the register equals SYNC_WORD after a shift: in_frame=1, bit counter=0. Later bits in the same cycle go to byte assembly.
- in_frame: each decoded bit shifts into the byte register MSB-first.
  - On the 8th bit: out_byte loads the byte, bit counter wraps to 0.
  - out_valid is high for exactly the one cycle after the edge that sampled the completing half-bit.
- in_frame stays 1 until a violation or reset; idle cycles (num_bits=0) never end a frame.
- Outputs are all registered. Latency from sampling the final half-bit to out_valid/out_byte is 1 cycle.
- Residue persists across idle cycles.

Test Plan:
- Reset 5 cycles, then stream Manchester(0xAAAAD5AABBCCDD), 112 half-bits MSB first, 1 half-bit then 2 per cycle.
  - locked after 8 bits; in_frame after the D5 byte.
  - out_valid pulses 4 times with 0xAA, 0xBB, 0xCC, 0xDD; code_err never.
- Same stream at 3 half-bits per cycle (final cycle partial) -> identical bytes and order.
- Prepend one stray 0 half-bit -> single code_err pulse at start, then lock and bytes AA, BB, CC, DD.
- Same stream with random num_bits=0 cycles and num_bits=5/7 cycles interleaved (bits ignored) -> identical bytes; residue preserved.
- After sync and 3 bits of 0xAA, inject half-bits 11:
  - code_err pulses; locked and in_frame drop.
  - no out_valid until a fresh ≥8-bit 0xAA preamble plus 0xD5 is received.
  - The next byte is then decoded correctly.
- areset mid-frame with an odd residue pending:
  - all outputs 0 next cycle, residue discarded.
  - full stream afterwards decodes normally.
